inst_fetch_unit: RTL and testbench

//  Instruction fetch stage. Feeds the branch/decode logic, i.e. it is the producer of the

---
 rtl/inst_fetch_unit.sv | 121 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, word-wide IMEM with synchronous read, valid/ready output.
// Optional perf counters (fetch_cnt, redirect_cnt) enabled by defining IFETCH_PERF_CNT_EN.
module inst_fetch_unit #(
    parameter int unsigned      PC_W      = 8,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      HALT_INST = 32'hFC00_0000,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [31:0]       inst_out,
    output logic [PC_W-1:0]   inst_pc,
    output logic              halted,
    output logic              misalign_err,
    input  logic              ld_en,
    input  logic [PC_W-3:0]   ld_addr,
    input  logic [31:0]       ld_data
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << (PC_W - 2);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_is_halt;
    logic              w_rd_en;
    logic [PC_W-1:0]   w_rd_pc;
    logic [PC_W-1:0]   w_redir_pc;
    logic [PC_W-1:0]   w_seq_pc;

    // Loader port has no reset so programs can be written while rst_n is held low.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // A read happens only when a new instruction is presented; redirect wins over everything.
    always_comb begin
        w_accept   = inst_valid & inst_ready;
        w_is_halt  = (inst_out == HALT_INST);
        w_redir_pc = {redirect_pc[PC_W-1:2], 2'b00};
        w_seq_pc   = inst_pc + PC_W'(4);
        w_rd_en    = 1'b0;
        w_rd_pc    = w_seq_pc;
        if (redirect_valid) begin
            w_rd_en = 1'b1;
            w_rd_pc = w_redir_pc;
        end else begin
            case (r_state)
                S_BOOT: begin
                    w_rd_en = 1'b1;
                    w_rd_pc = RESET_PC;
                end
                S_RUN: begin
                    w_rd_en = w_accept & ~w_is_halt;
                end
                default: begin
                    w_rd_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_BOOT;
            inst_valid   <= 1'b0;
            inst_out     <= '0;
            inst_pc      <= RESET_PC;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid & (|redirect_pc[1:0]);
            if (w_rd_en) begin
                inst_out   <= r_mem[w_rd_pc[PC_W-1:2]];
                inst_pc    <= w_rd_pc;
                inst_valid <= 1'b1;
                halted     <= 1'b0;
                r_state    <= S_RUN;
            end else if ((r_state == S_RUN) && w_accept && w_is_halt) begin
                inst_valid <= 1'b0;
                halted     <= 1'b1;
                r_state    <= S_HALT;
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (w_accept && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (redirect_valid && (redirect_cnt != '1)) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, hand-written corner sequences, and random
// stimulus checked against a transaction-level reference model.
module tb_inst_fetch_unit;

    localparam int unsigned PC_W = 8;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [7:0]  inst_pc;
    logic        halted;
    logic        misalign_err;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] redirect_cnt;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    inst_fetch_unit #(
        .PC_W(PC_W),
        .RESET_PC(8'h00),
        .HALT_INST(HALT),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_ready(inst_ready),
        .inst_valid(inst_valid),
        .inst_out(inst_out),
        .inst_pc(inst_pc),
        .halted(halted),
        .misalign_err(misalign_err),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_cnt(fetch_cnt),
        .redirect_cnt(redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the consumer should see, derived from the fetch rules directly.
    logic [31:0] ref_mem [64];
    bit          m_booted;
    bit          m_valid;
    bit          m_halted;
    bit          m_mis;
    logic [7:0]  m_pc;
    logic [31:0] m_inst;
    int unsigned m_fetch;
    int unsigned m_redir;

    task automatic model_reset();
        m_booted = 1'b0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
        m_pc     = 8'h00;
        m_inst   = 32'h0;
        m_fetch  = 0;
        m_redir  = 0;
    endtask

    task automatic model_present(input logic [7:0] p);
        m_pc    = p;
        m_inst  = ref_mem[p[7:2]];
        m_valid = 1'b1;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_mis = 1'b0;
            if (redirect_valid) begin
                if (m_valid && inst_ready) m_fetch++;
                m_redir++;
                m_mis = (redirect_pc % 4) != 0;
                model_present(redirect_pc - (redirect_pc % 4));
                m_halted = 1'b0;
                m_booted = 1'b1;
            end else if (!m_booted) begin
                model_present(8'h00);
                m_booted = 1'b1;
            end else if (m_valid && inst_ready) begin
                m_fetch++;
                if (m_inst == HALT) begin
                    m_valid  = 1'b0;
                    m_halted = 1'b1;
                end else begin
                    model_present(8'((int'(m_pc) + 4) % 256));
                end
            end
        end
        if (ld_en) ref_mem[ld_addr] = ld_data;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string nm, input logic v, input logic h, input logic mis,
                         input logic [7:0] pc, input logic [31:0] inst);
        vectors++;
        if ({inst_valid, halted, misalign_err, inst_pc, inst_out} !== {v, h, mis, pc, inst}) begin
            miscompares++;
            $display("FAIL %s: got v=%0b h=%0b mis=%0b pc=%02h inst=%08h, want v=%0b h=%0b mis=%0b pc=%02h inst=%08h",
                     nm, inst_valid, halted, misalign_err, inst_pc, inst_out, v, h, mis, pc, inst);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, m_valid, m_halted, m_mis, m_pc, m_inst);
`ifdef IFETCH_PERF_CNT_EN
        vectors++;
        if ({fetch_cnt, redirect_cnt} !== {16'(m_fetch > 65535 ? 65535 : m_fetch),
                                           16'(m_redir > 65535 ? 65535 : m_redir)}) begin
            miscompares++;
            $display("FAIL %s_cnt: got fetch=%0d redir=%0d, want fetch=%0d redir=%0d",
                     nm, fetch_cnt, redirect_cnt, m_fetch, m_redir);
        end
`endif
    endtask

    typedef struct {
        logic        rv;
        logic [7:0]  rpc;
        logic        rdy;
        logic        ev;
        logic        em;
        logic [7:0]  epc;
        logic [31:0] einst;
    } vec_t;

    vec_t tbl [11];

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        inst_ready     = 1'b0;
        ld_en          = 1'b0;
        ld_addr        = 6'd0;
        ld_data        = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        model_reset();

        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 32'hA000_0000};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 32'hA000_0001};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h04, 32'hA000_0001};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h04, 32'hA000_0001};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h08, 32'hA000_0002};
        tbl[5]  = '{1'b1, 8'h28, 1'b0, 1'b1, 1'b0, 8'h28, 32'hA000_000A};
        tbl[6]  = '{1'b1, 8'h2A, 1'b1, 1'b1, 1'b1, 8'h28, 32'hA000_000A};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h28, 32'hA000_000A};
        tbl[8]  = '{1'b1, 8'hFC, 1'b1, 1'b1, 1'b0, 8'hFC, 32'hA000_003F};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 32'hA000_0000};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 32'hA000_0001};

        #2;
        for (int i = 0; i < 64; i++) begin
            ld_en   = 1'b1;
            ld_addr = 6'(i);
            ld_data = 32'hA000_0000 | 32'(i);
            tick();
        end
        ld_en = 1'b0;
        check("reset_state", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            inst_ready     = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d", i), tbl[i].ev, 1'b0, tbl[i].em, tbl[i].epc, tbl[i].einst);
        end
        redirect_valid = 1'b0;

        // Plant HALT at word 3 while holding 4/B, then run into it
        inst_ready = 1'b0;
        ld_en = 1'b1; ld_addr = 6'd3; ld_data = HALT;
        tick();
        ld_en = 1'b0;
        check("ld_while_hold", 1'b1, 1'b0, 1'b0, 8'h04, 32'hA000_0001);
        inst_ready = 1'b1;
        tick(); check("pre_halt_8",  1'b1, 1'b0, 1'b0, 8'h08, 32'hA000_0002);
        tick(); check("halt_word",   1'b1, 1'b0, 1'b0, 8'h0C, HALT);
        tick(); check("halted",      1'b0, 1'b1, 1'b0, 8'h0C, HALT);
        tick(); check("halted_stay", 1'b0, 1'b1, 1'b0, 8'h0C, HALT);
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        tick(); check("halt_exit", 1'b1, 1'b0, 1'b0, 8'h00, 32'hA000_0000);
        redirect_valid = 1'b0;

        // Same-word write and read on one edge: read returns old data
        ld_en = 1'b1; ld_addr = 6'd1; ld_data = 32'h5555_1234;
        tick(); check("rd_old_data", 1'b1, 1'b0, 1'b0, 8'h04, 32'hA000_0001);
        ld_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 8'h04;
        tick(); check("rd_new_data", 1'b1, 1'b0, 1'b0, 8'h04, 32'h5555_1234);
        redirect_valid = 1'b0;

        // Redirect in the cycle HALT is accepted: redirect wins, no halt
        tick(); check("to_8",  1'b1, 1'b0, 1'b0, 8'h08, 32'hA000_0002);
        tick(); check("to_C",  1'b1, 1'b0, 1'b0, 8'h0C, HALT);
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        tick(); check("halt_vs_redirect", 1'b1, 1'b0, 1'b0, 8'h10, 32'hA000_0004);
        redirect_valid = 1'b0;
        tick(); check("to_14", 1'b1, 1'b0, 1'b0, 8'h14, 32'hA000_0005);

        // Asynchronous reset mid-run
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        rst_n = 1'b1;
        tick(); check_model("reboot");
        check("reboot_const", 1'b1, 1'b0, 1'b0, 8'h00, 32'hA000_0000);

        for (int i = 0; i < 1500; i++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 8'($urandom);
            ld_en          = ($urandom_range(0, 7) == 0);
            ld_addr        = 6'($urandom);
            ld_data        = ($urandom_range(0, 15) == 0) ? HALT : 32'($urandom);
            tick();
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
